// File: rtl/ps2_key_sequencer.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, decodes 11-bit frames,
// tracks F0/E0 prefixes, maps make codes to key indices and queues events in a 4-deep FIFO.
module ps2_key_sequencer #(
   parameter int TIMEOUT_CYCLES = 27000
) (
   input  logic       clock27,
   input  logic       resetN,
   input  logic       keyboardClock,
   input  logic       keyboardData,
   output logic       keyValid,
   input  logic       keyReady,
   output logic [7:0] keyDataOut,
   output logic [4:0] keyIndex,
   output logic       keyRelease,
   output logic       frameError,
   output logic       overflow
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // Data bits plus parity bit must contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return (^d) ^ p;
   endfunction

   // Returns {hit, index} for the supported make codes.
   function automatic logic [5:0] key_lookup(input logic [7:0] c);
      case (c)
         8'h1C:   key_lookup = {1'b1, 5'd0};
         8'h32:   key_lookup = {1'b1, 5'd1};
         8'h21:   key_lookup = {1'b1, 5'd2};
         8'h23:   key_lookup = {1'b1, 5'd3};
         8'h24:   key_lookup = {1'b1, 5'd4};
         8'h2B:   key_lookup = {1'b1, 5'd5};
         8'h34:   key_lookup = {1'b1, 5'd6};
         8'h33:   key_lookup = {1'b1, 5'd7};
         8'h43:   key_lookup = {1'b1, 5'd8};
         8'h3B:   key_lookup = {1'b1, 5'd9};
         8'h16:   key_lookup = {1'b1, 5'd10};
         8'h1E:   key_lookup = {1'b1, 5'd11};
         8'h26:   key_lookup = {1'b1, 5'd12};
         8'h25:   key_lookup = {1'b1, 5'd13};
         8'h2E:   key_lookup = {1'b1, 5'd14};
         8'h36:   key_lookup = {1'b1, 5'd15};
         8'h3D:   key_lookup = {1'b1, 5'd16};
         8'h3E:   key_lookup = {1'b1, 5'd17};
         8'h46:   key_lookup = {1'b1, 5'd18};
         8'h45:   key_lookup = {1'b1, 5'd19};
         8'h5A:   key_lookup = {1'b1, 5'd20};
         default: key_lookup = {1'b0, 5'd0};
      endcase
   endfunction

   logic          r_kclk_s1, r_kclk_s2, r_kclk_d;
   logic          r_kdat_s1, r_kdat_s2;
   state_t        r_state, w_state_nxt;
   logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic          r_par, w_par_nxt;
   logic [TW-1:0] r_tcnt, w_tcnt_nxt;
   logic          r_byte_vld, w_byte_vld_nxt;
   logic          w_frame_err;
   logic          r_break, w_break_nxt;
   logic          r_ext, w_ext_nxt;
   logic          w_push;
   logic [13:0]   w_entry;
   logic [5:0]    w_lookup;
   logic [13:0]   r_mem [0:3];
   logic [1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
   logic [2:0]    r_count, w_count_nxt;
   logic          w_pop, w_full, w_wr, w_ovf_nxt;
   logic [13:0]   w_head_nxt;
   logic          r_key_valid, r_key_rel, r_frame_err, r_overflow;
   logic [7:0]    r_key_code;
   logic [4:0]    r_key_idx;
   logic          w_fall, w_dat;

   assign w_fall = r_kclk_d & ~r_kclk_s2;
   assign w_dat  = r_kdat_s2;

   // Two-flop synchronizers plus delayed clock for falling-edge detection.
   always_ff @(posedge clock27 or negedge resetN) begin
      if (!resetN) begin
         r_kclk_s1 <= 1'b1;
         r_kclk_s2 <= 1'b1;
         r_kclk_d  <= 1'b1;
         r_kdat_s1 <= 1'b1;
         r_kdat_s2 <= 1'b1;
      end else begin
         r_kclk_s1 <= keyboardClock;
         r_kclk_s2 <= r_kclk_s1;
         r_kclk_d  <= r_kclk_s2;
         r_kdat_s1 <= keyboardData;
         r_kdat_s2 <= r_kdat_s1;
      end
   end

   // Receive FSM next state, bit assembly, timeout and frame checking.
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_par_nxt      = r_par;
      w_tcnt_nxt     = '0;
      w_byte_vld_nxt = 1'b0;
      w_frame_err    = 1'b0;
      if (w_fall) begin
         case (r_state)
            ST_IDLE: begin
               if (!w_dat) begin
                  w_state_nxt   = ST_DATA;
                  w_bit_cnt_nxt = 3'd0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_DATA: begin
               w_shift_nxt   = {w_dat, r_shift[7:1]};
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = ST_PARITY;
               end else begin
                  w_state_nxt = ST_DATA;
               end
            end
            ST_PARITY: begin
               w_par_nxt   = w_dat;
               w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
               w_state_nxt   = ST_IDLE;
               w_bit_cnt_nxt = 3'd0;
               if (w_dat && odd_parity_ok(r_shift, r_par)) begin
                  w_byte_vld_nxt = 1'b1;
               end else begin
                  w_frame_err = 1'b1;
               end
            end
            default: begin
               w_state_nxt   = ST_IDLE;
               w_bit_cnt_nxt = 3'd0;
            end
         endcase
      end else if (r_state != ST_IDLE) begin
         if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 3'd0;
            w_frame_err   = 1'b1;
         end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
         end
      end else begin
         w_tcnt_nxt = '0;
      end
   end

   // Prefix tracking and event generation, one cycle after the stop bit.
   always_comb begin
      w_lookup    = key_lookup(r_shift);
      w_entry     = {r_shift, w_lookup[4:0], r_break};
      w_push      = 1'b0;
      w_break_nxt = r_break;
      w_ext_nxt   = r_ext;
      if (w_frame_err) begin
         w_break_nxt = 1'b0;
         w_ext_nxt   = 1'b0;
      end else if (r_byte_vld) begin
         if (r_shift == 8'hF0) begin
            w_break_nxt = 1'b1;
         end else if (r_shift == 8'hE0) begin
            w_ext_nxt = 1'b1;
         end else begin
            w_break_nxt = 1'b0;
            w_ext_nxt   = 1'b0;
            w_push      = ~r_ext & w_lookup[5];
         end
      end else begin
         w_push = 1'b0;
      end
   end

   // FIFO bookkeeping; the next head is precomputed so outputs are registered.
   always_comb begin
      w_pop     = r_key_valid & keyReady;
      w_full    = (r_count == 3'd4);
      w_wr      = w_push & (~w_full | w_pop);
      w_ovf_nxt = r_overflow | (w_push & w_full & ~w_pop);
      case ({w_wr, w_pop})
         2'b10:   w_count_nxt = r_count + 3'd1;
         2'b01:   w_count_nxt = r_count - 3'd1;
         default: w_count_nxt = r_count;
      endcase
      w_rd_ptr_nxt = r_rd_ptr + {1'b0, w_pop};
      if (w_count_nxt == 3'd0) begin
         w_head_nxt = 14'd0;
      end else if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) begin
         w_head_nxt = w_entry;
      end else begin
         w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
   end

   // Sequential state for receiver, prefixes, FIFO and outputs.
   always_ff @(posedge clock27 or negedge resetN) begin
      if (!resetN) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'd0;
         r_par       <= 1'b0;
         r_tcnt      <= '0;
         r_byte_vld  <= 1'b0;
         r_break     <= 1'b0;
         r_ext       <= 1'b0;
         for (int i = 0; i < 4; i++) r_mem[i] <= 14'd0;
         r_wr_ptr    <= 2'd0;
         r_rd_ptr    <= 2'd0;
         r_count     <= 3'd0;
         r_key_valid <= 1'b0;
         r_key_code  <= 8'd0;
         r_key_idx   <= 5'd0;
         r_key_rel   <= 1'b0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_par       <= w_par_nxt;
         r_tcnt      <= w_tcnt_nxt;
         r_byte_vld  <= w_byte_vld_nxt;
         r_break     <= w_break_nxt;
         r_ext       <= w_ext_nxt;
         if (w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
         end
         r_wr_ptr    <= r_wr_ptr + {1'b0, w_wr};
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_count     <= w_count_nxt;
         r_key_valid <= (w_count_nxt != 3'd0);
         r_key_code  <= w_head_nxt[13:6];
         r_key_idx   <= w_head_nxt[5:1];
         r_key_rel   <= w_head_nxt[0];
         r_frame_err <= w_frame_err;
         r_overflow  <= w_ovf_nxt;
      end
   end

   assign keyValid   = r_key_valid;
   assign keyDataOut = r_key_code;
   assign keyIndex   = r_key_idx;
   assign keyRelease = r_key_rel;
   assign frameError = r_frame_err;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench: directed PS/2 frames push expected events; a monitor pops and compares.
module tb_ps2_key_sequencer;

   localparam int T    = 200;
   localparam int HALF = 5;

   typedef struct packed {
      logic [7:0] code;
      logic [4:0] idx;
      logic       rel;
   } ev_t;

   logic       clock27 = 1'b0;
   logic       resetN = 1'b0;
   logic       keyboardClock = 1'b1;
   logic       keyboardData = 1'b1;
   logic       keyValid;
   logic       keyReady = 1'b0;
   logic [7:0] keyDataOut;
   logic [4:0] keyIndex;
   logic       keyRelease;
   logic       frameError;
   logic       overflow;

   ev_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  cyc = 0;
   int  err_pulses = 0;
   int  err_cyc = 0;
   int  last_fall_cyc = 0;
   int  err_base;

   ps2_key_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .clock27(clock27), .resetN(resetN),
      .keyboardClock(keyboardClock), .keyboardData(keyboardData),
      .keyValid(keyValid), .keyReady(keyReady),
      .keyDataOut(keyDataOut), .keyIndex(keyIndex), .keyRelease(keyRelease),
      .frameError(frameError), .overflow(overflow)
   );

   always #5 clock27 = ~clock27;

   always @(posedge clock27) cyc++;

   // Monitor: pop and compare every accepted event, count frameError pulses.
   always @(negedge clock27) begin
      if (resetN && frameError) begin
         err_pulses++;
         err_cyc = cyc;
      end
      if (resetN && keyValid && keyReady) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event got code=%h idx=%0d rel=%0b, expected none",
                     keyDataOut, keyIndex, keyRelease);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (keyDataOut !== e.code || keyIndex !== e.idx || keyRelease !== e.rel) begin
               n_err++;
               $display("FAIL event got code=%h idx=%0d rel=%0b, expected code=%h idx=%0d rel=%0b",
                        keyDataOut, keyIndex, keyRelease, e.code, e.idx, e.rel);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic expect_ev(input logic [7:0] c, input logic [4:0] i, input logic r);
      ev_t e;
      e.code = c;
      e.idx  = i;
      e.rel  = r;
      exp_q.push_back(e);
   endtask

   task automatic ps2_bit(input logic b);
      @(posedge clock27); #2;
      keyboardData = b;
      repeat (HALF) @(posedge clock27);
      #2;
      keyboardClock = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(posedge clock27);
      #2;
      keyboardClock = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(~bad_stop);
      keyboardData = 1'b1;
      repeat (10) @(posedge clock27);
      #2;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock27);
      #2;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_keyValid"}, {31'd0, keyValid}, 32'd0);
      check({tag, "_keyDataOut"}, {24'd0, keyDataOut}, 32'd0);
      check({tag, "_keyIndex"}, {27'd0, keyIndex}, 32'd0);
      check({tag, "_keyRelease"}, {31'd0, keyRelease}, 32'd0);
      check({tag, "_frameError"}, {31'd0, frameError}, 32'd0);
      check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
   endtask

   initial begin
      // Reset state
      wait_cycles(3);
      check_all_zero("reset");
      resetN = 1'b1;
      wait_cycles(3);

      // Single press held until consumer accepts it
      expect_ev(8'h1C, 5'd0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      wait_cycles(20);
      check("held_valid", {31'd0, keyValid}, 32'd1);
      check("held_code", {24'd0, keyDataOut}, 32'h1C);
      keyReady = 1'b1;
      wait_cycles(5);
      check("drained_valid", {31'd0, keyValid}, 32'd0);
      check("drained_code", {24'd0, keyDataOut}, 32'd0);

      // Release via F0 prefix
      expect_ev(8'h45, 5'd19, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h45, 1'b0, 1'b0);

      // Extended codes suppressed, next plain code is a press
      expect_ev(8'h5A, 5'd20, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b0);
      check("good_frames_no_error", err_pulses, 32'd0);

      // Bad parity and bad stop; the error also clears a pending F0
      err_base = err_pulses;
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b1, 1'b0);
      send_frame(8'h32, 1'b0, 1'b1);
      check("bad_frame_errors", err_pulses - err_base, 32'd2);
      expect_ev(8'h16, 5'd10, 1'b0);
      send_frame(8'h16, 1'b0, 1'b0);

      // Overflow: six events into a 4-deep FIFO
      keyReady = 1'b0;
      wait_cycles(5);
      expect_ev(8'h1C, 5'd0, 1'b0);
      expect_ev(8'h32, 5'd1, 1'b0);
      expect_ev(8'h21, 5'd2, 1'b0);
      expect_ev(8'h23, 5'd3, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'h32, 1'b0, 1'b0);
      send_frame(8'h21, 1'b0, 1'b0);
      send_frame(8'h23, 1'b0, 1'b0);
      check("not_overflowed_yet", {31'd0, overflow}, 32'd0);
      send_frame(8'h24, 1'b0, 1'b0);
      send_frame(8'h2B, 1'b0, 1'b0);
      check("overflow_set", {31'd0, overflow}, 32'd1);
      check("full_head_code", {24'd0, keyDataOut}, 32'h1C);
      keyReady = 1'b1;
      wait_cycles(10);
      check("after_drain_valid", {31'd0, keyValid}, 32'd0);
      check("overflow_sticky", {31'd0, overflow}, 32'd1);

      // Timeout after 4 data bits, timed from the synchronized last edge
      err_base = err_pulses;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      keyboardData = 1'b1;
      wait_cycles(T + 20);
      check("timeout_error", err_pulses - err_base, 32'd1);
      check("timeout_latency", err_cyc - last_fall_cyc, T + 3);
      expect_ev(8'h3B, 5'd9, 1'b0);
      send_frame(8'h3B, 1'b0, 1'b0);

      // Reset with a queued event and a partial frame in flight
      keyReady = 1'b0;
      send_frame(8'h24, 1'b0, 1'b0);
      check("queued_before_reset", {31'd0, keyValid}, 32'd1);
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b0);
      resetN = 1'b0;
      wait_cycles(3);
      check_all_zero("midreset");
      resetN = 1'b1;
      wait_cycles(20);
      check("post_reset_valid", {31'd0, keyValid}, 32'd0);
      keyReady = 1'b1;
      expect_ev(8'h46, 5'd18, 1'b0);
      send_frame(8'h46, 1'b0, 1'b0);
      wait_cycles(10);

      check("all_events_seen", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 27000, meaning clock27 cycles without a keyboardClock falling edge before an in-progress frame is abandoned (1 ms at 27 MHz).
REQ-002 SHALL have port clock27  in  1  system clock; the only clock; all logic on its rising edge.
REQ-003 SHALL have port resetN  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port keyboardClock  in  1  PS/2 clock line, asynchronous to clock27.
REQ-005 SHALL have port keyboardData  in  1  PS/2 data line, asynchronous to clock27.
REQ-006 SHALL have port keyValid  out  1  FIFO head holds a key event.
REQ-007 SHALL have port keyReady  in  1  consumer accepts the head event.
REQ-008 SHALL have port keyDataOut  out  8  raw make scan code of head event.
REQ-009 SHALL have port keyIndex  out  5  mapped key index of head event.
REQ-010 SHALL have port keyRelease  out  1  head event is a release (1) or press (0).
REQ-011 SHALL have port frameError  out  1  one-cycle pulse per rejected or timed-out frame.
REQ-012 SHALL have port overflow  out  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-013 SHALL pass keyboardClock and keyboardData through 2-flop synchronizers; a falling edge is synchronized clock high then low on consecutive cycles; data is sampled on that edge-detect cycle.
REQ-014 SHALL run receive FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, advancing only on falling edges.
REQ-015 In IDLE, an edge with data=1 (bad start bit) SHALL be ignored without frameError.
REQ-016 A frame with odd parity failing (data bits plus parity bit not odd) or stop bit=0 SHALL be discarded, pulse frameError, and clear both prefix flags.
REQ-017 In any non-IDLE state, TIMEOUT_CYCLES consecutive cycles without a falling edge SHALL return FSM to IDLE, pulse frameError, and clear both prefix flags.
REQ-018 Valid byte F0 SHALL set breakPending; valid byte E0 SHALL set extPending; neither pushes an event.
REQ-019 Any other valid byte SHALL clear both flags in the same cycle; it is pushed only if extPending was 0 and it is in the key table, with keyRelease = prior breakPending.
REQ-020 Key table (code->index) SHALL be: A 1C->0, B 32->1, C 21->2, D 23->3, E 24->4, F 2B->5, G 34->6, H 33->7, I 43->8, J 3B->9, 1 16->10, 2 1E->11, 3 26->12, 4 25->13, 5 2E->14, 6 36->15, 7 3D->16, 8 3E->17, 9 46->18, 0 45->19, Enter 5A->20; all other codes are silently dropped.
REQ-021 Push SHALL occur the cycle after the stop-bit edge is sampled; keyValid SHALL rise the following cycle if the FIFO was empty.
REQ-022 FIFO SHALL be 4 entries of {code, index, release}, first-in first-out, with 3-bit occupancy count; pointers wrap modulo 4.
REQ-023 Pop SHALL occur on a cycle with keyValid=1 and keyReady=1; keyReady while empty has no effect.
REQ-024 Outputs keyDataOut/keyIndex/keyRelease SHALL show the head entry while keyValid=1 and SHALL be 0 while empty.
REQ-025 Push when full without simultaneous pop SHALL drop the new event and set overflow; push and pop in the same cycle when full SHALL accept both, count unchanged.
REQ-026 overflow SHALL remain 1 until reset.

Reset
REQ-027 resetN low SHALL immediately force: FSM IDLE, bit counter 0, timeout counter 0, prefix flags 0, FIFO empty, synchronizers to 1, keyValid 0, keyDataOut 0, keyIndex 0, keyRelease 0, frameError 0, overflow 0.
REQ-028 A frame in flight when reset asserts SHALL be abandoned; after release, reception restarts from IDLE with no recovery of partial data.

Verification
REQ-029 Frame 1C (parity 0, stop 1) -> one event code 1C, index 0, release 0; keyValid held until keyReady.
REQ-030 Frames F0,45 -> one event code 45, index 19, release 1; no event for F0.
REQ-031 Frames E0,75 then E0,F0,75 then 5A -> only one event: code 5A, index 20, release 0.
REQ-032 Frame 1C with wrong parity, then frame with stop bit 0 -> two frameError pulses, no events; next good 16 -> index 10.
REQ-033 keyReady=0, six frames 1C,32,21,23,24,2B -> FIFO holds 1C,32,21,23; overflow=1; draining yields indices 0,1,2,3 in order, then keyValid=0.
REQ-034 Stop toggling keyboardClock after 4 data bits -> frameError pulse exactly TIMEOUT_CYCLES after last edge; subsequent good 3B -> index 9; resetN pulse mid-frame -> all outputs 0, no event from partial frame.
